hazard_scoreboard_cu: RTL
=========================

Name: hazard_scoreboard_cu

Overview:
Parametrised decode-stage hazard unit for the MIPS pipeline, successor to the combinational hazard/forward unit. It handles forwarding from NFWD in-order stages and load-use stalls. It also adds a per-register scoreboard and occupancy tracking for a non-pipelined multi-cycle unit (mul/div), including WAW, structural and condition-flag stalls. It sits beside the decode stage and drives the forward muxes and the decode stall.

Parameters:
NREG, 32, number of architectural registers; register 0 is hardwired zero.
RW, $clog2(NREG), register index width.
NFWD, 2, number of in-order forwarding stages (index 0 = youngest, i.e. E).
LW, 5, width of the multi-cycle latency field.
FW, $clog2(NFWD+2), width of a forward-select code.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
d_ra, d_rb  in  RW each  decode source registers.
d_need_ra, d_need_rb  in  1 each  decode actually reads ra/rb.
d_rn  in  RW  decode destination register.
d_wreg  in  1  decode instruction writes d_rn.
d_mc  in  1  decode instruction is a multi-cycle op.
d_mc_lat  in  LW  latency of that op in cycles; 0 is treated as 1.
d_cond_use  in  1  decode branch consumes condition flags (not NEVER/ALWAYS/MIPS_E/MIPS_NE).
d_valid  in  1  decode holds a real instruction.
flush  in  1  kill the decode instruction this cycle; it issues nothing.
s_wreg  in  NFWD  stage s writes its register.
s_rn  in  NFWD*RW  stage s destination; slice s = bits [s*RW +: RW].
s_ready  in  NFWD  stage s result is available for forwarding (0 = load still in flight).
e_setcond  in  1  E-stage instruction writes condition flags.
d_available  out  1  decode may advance this cycle.
forward_q1, forward_q2  out  FW each  0 = regfile, s+1 = stage s, NFWD+1 = multi-cycle result.
mc_busy  out  1  multi-cycle unit occupied.
mc_done  out  1  multi-cycle result is on the writeback bus this cycle.
mc_rn  out  RW  destination register of the completing op.

Behaviour:
- Issue: d_issue = d_valid & ~flush & d_available. Only an issued instruction changes state.
- Scoreboard: NREG pending bits.
  - Set for d_rn on an issue with d_mc & d_wreg & d_rn != 0.
  - Cleared for mc_rn at the end of a cycle with mc_done.
  - If the same register is cleared and set in the same cycle, set wins.
- Multi-cycle tracker:
  - On an mc issue in cycle T with latency L: cnt <= L; mc_rn and the wreg flag are latched.
  - mc_busy is 1 in cycles T+1 .. T+L.
  - mc_done is 1 in cycle T+L only (the cycle where cnt == 1). cnt decrements while nonzero.
  - Back-to-back: an mc issue is allowed in the mc_done cycle; the counter reloads and mc_busy stays high.
  - mc_done is asserted even when the op has no destination; the pending bit is untouched in that case.
- Forward select, per operand X in {a, b}, when need_X is set and rX != 0:
  - The lowest stage s with s_wreg[s] & s_rn[s] == rX wins, giving code s+1.
  - Otherwise, if mc_done & mc_rn == rX, the code is NFWD+1.
  - Otherwise the code is 0. If need_X = 0 or rX = 0, the code is 0.
- Stall: d_available = 0 if any of the following hold:
  - (a) The winning stage match has s_ready = 0 (load-use).
  - (b) The operand is pending and not completing this cycle with the code at NFWD+1.
  - (c) d_mc and mc_busy and not mc_done (structural).
  - (d) d_wreg and d_rn pending and not completing this cycle (WAW).
  - (e) d_cond_use and e_setcond.
  - d_available ignores d_valid.
- Forward outputs and d_available are combinational. mc_busy, mc_done and mc_rn are registered.
- Reset (asynchronous, any time, including mid-operation): pending = 0, cnt = 0, mc_busy = 0, mc_done = 0, mc_rn = 0. The in-flight op is abandoned.
- flush does not cancel an already-issued multi-cycle op.

Decomposition:
- Package hazard_pkg holds the FWD_RF = 0 constant, the function giving code NFWD+1, and the stall-reason enum (for assertions/debug).
- JMP_* encodings stay in common.v.
- One sub-module, mc_tracker: counter, latched rn, busy/done generation.

Test Plan:
1. Stage 0 writes r5 with s_ready=1, stage 1 also writes r5, decode reads ra=5 -> forward_q1=1, d_available=1.
2. Stage 0 writes r7 with s_ready=0, d_rb=7, need_rb=1 -> d_available=0. The next cycle (r7 now in stage 1, ready) -> forward_q2=2, d_available=1.
3. Issue mul r9 with lat=4 at T; dependent read of r9 -> stall T+1..T+3. At T+4 mc_done=1, mc_rn=9, forward=NFWD+1 (3), d_available=1. At T+5 pending[9]=0.
4. Second mc op while busy -> stalls until the mc_done cycle, then issues there; mc_busy stays 1 without a gap.
5. d_wreg to r9 while r9 is pending -> stall (WAW). d_cond_use=1 with e_setcond=1 -> d_available=0.
6. rst pulsed mid-op with cnt=2 -> mc_busy and mc_done drop immediately, no later mc_done, r9 is no longer stalled; ra=0 never forwards or stalls.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants, forward-code helper and stall-reason encoding for the
// decode-stage hazard/scoreboard unit.
package hazard_pkg;

    localparam int FWD_RF = 0;

    typedef enum logic [2:0] {
        STALL_NONE      = 3'd0,
        STALL_LOAD_USE  = 3'd1,
        STALL_MC_PEND   = 3'd2,
        STALL_STRUCT    = 3'd3,
        STALL_WAW       = 3'd4,
        STALL_COND      = 3'd5
    } stall_reason_e;

    // Forward code that selects the multi-cycle writeback bus.
    function automatic int fwd_mc_code(input int nfwd);
        return nfwd + 1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_cu_if.sv
// Decode/pipeline-facing signal bundle of the hazard unit. The pipeline side
// uses the master modport, the hazard unit the slave modport.
interface hazard_scoreboard_cu_if
    import hazard_pkg::*;
#(
    parameter int NREG = 32,
    parameter int NFWD = 2,
    parameter int LW   = 5,
    parameter int RW   = $clog2(NREG),
    parameter int FW   = $clog2(NFWD + 2)
);
    logic [RW-1:0]      d_ra;
    logic [RW-1:0]      d_rb;
    logic               d_need_ra;
    logic               d_need_rb;
    logic [RW-1:0]      d_rn;
    logic               d_wreg;
    logic               d_mc;
    logic [LW-1:0]      d_mc_lat;
    logic               d_cond_use;
    logic               d_valid;
    logic               flush;
    logic [NFWD-1:0]    s_wreg;
    logic [NFWD*RW-1:0] s_rn;
    logic [NFWD-1:0]    s_ready;
    logic               e_setcond;
    logic               d_available;
    logic [FW-1:0]      forward_q1;
    logic [FW-1:0]      forward_q2;
    logic               mc_busy;
    logic               mc_done;
    logic [RW-1:0]      mc_rn;
    stall_reason_e      stall_reason;

    modport master (
        output d_ra, d_rb, d_need_ra, d_need_rb, d_rn, d_wreg, d_mc, d_mc_lat,
               d_cond_use, d_valid, flush, s_wreg, s_rn, s_ready, e_setcond,
        input  d_available, forward_q1, forward_q2, mc_busy, mc_done, mc_rn,
               stall_reason
    );

    modport slave (
        input  d_ra, d_rb, d_need_ra, d_need_rb, d_rn, d_wreg, d_mc, d_mc_lat,
               d_cond_use, d_valid, flush, s_wreg, s_rn, s_ready, e_setcond,
        output d_available, forward_q1, forward_q2, mc_busy, mc_done, mc_rn,
               stall_reason
    );

endinterface

// File: rtl/hazard_scoreboard_cu_mc_tracker.sv
// Occupancy tracker for the non-pipelined multi-cycle unit: latency counter,
// latched destination and registered busy/done flags.
module mc_tracker #(
    parameter int RW = 5,
    parameter int LW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    input  logic [LW-1:0] lat,
    input  logic [RW-1:0] rn,
    input  logic          wreg,
    output logic          mc_busy,
    output logic          mc_done,
    output logic [RW-1:0] mc_rn,
    output logic          mc_wreg
);

    logic [LW-1:0] cnt_r;
    logic [LW-1:0] cnt_next_s;
    logic [LW-1:0] lat_eff_s;
    logic          busy_r;
    logic          done_r;
    logic [RW-1:0] rn_r;
    logic          wreg_r;

    // Next counter value; a reload in the done cycle keeps busy continuous.
    always_comb begin
        cnt_next_s = cnt_r;
        lat_eff_s  = (lat == {LW{1'b0}}) ? LW'(1) : lat;
        if (issue) begin
            cnt_next_s = lat_eff_s;
        end else if (cnt_r != {LW{1'b0}}) begin
            cnt_next_s = cnt_r - LW'(1);
        end else begin
            cnt_next_s = {LW{1'b0}};
        end
    end

    // Counter and flags; busy/done are registered from the next count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= {LW{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            busy_r <= (cnt_next_s != {LW{1'b0}});
            done_r <= (cnt_next_s == LW'(1));
        end
    end

    // Destination of the op currently in the unit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rn_r   <= {RW{1'b0}};
            wreg_r <= 1'b0;
        end else if (issue) begin
            rn_r   <= rn;
            wreg_r <= wreg;
        end else begin
            rn_r   <= rn_r;
            wreg_r <= wreg_r;
        end
    end

    assign mc_busy = busy_r;
    assign mc_done = done_r;
    assign mc_rn   = rn_r;
    assign mc_wreg = wreg_r;

endmodule

// File: rtl/hazard_scoreboard_cu.sv
// Decode-stage hazard unit: forward selection from in-order stages and the
// multi-cycle unit, per-register scoreboard, and the decode stall.
module hazard_scoreboard_cu
    import hazard_pkg::*;
#(
    parameter int NREG = 32,
    parameter int RW   = $clog2(NREG),
    parameter int NFWD = 2,
    parameter int LW   = 5,
    parameter int FW   = $clog2(NFWD + 2)
) (
    input logic             clk,
    input logic             rst,
    hazard_scoreboard_cu_if.slave bus
);

    localparam logic [FW-1:0] FWD_RF_C = FW'(FWD_RF);
    localparam logic [FW-1:0] FWD_MC_C = FW'(fwd_mc_code(NFWD));

    typedef struct packed {
        logic [FW-1:0] code;
        logic          load_wait;
    } fwd_t;

    logic [NREG-1:0] pending_r;
    logic [NREG-1:0] set_mask_s;
    logic [NREG-1:0] clr_mask_s;
    fwd_t            fa_s;
    fwd_t            fb_s;
    logic            pend_a_s;
    logic            pend_b_s;
    logic            struct_s;
    logic            waw_s;
    logic            cond_s;
    stall_reason_e   stall_reason_s;
    logic            d_available_s;
    logic            issue_s;
    logic            mc_busy_s;
    logic            mc_done_s;
    logic [RW-1:0]   mc_rn_s;
    logic            mc_wreg_s;

    // Youngest matching stage wins over the multi-cycle bus; zero register never forwards.
    function automatic fwd_t fwd_lookup(
        input logic [RW-1:0]      rx,
        input logic               need,
        input logic [NFWD-1:0]    s_wreg,
        input logic [NFWD*RW-1:0] s_rn,
        input logic [NFWD-1:0]    s_ready,
        input logic               mc_done,
        input logic [RW-1:0]      mc_rn
    );
        fwd_t res;
        res.code      = FWD_RF_C;
        res.load_wait = 1'b0;
        if (need && (rx != {RW{1'b0}})) begin
            if (mc_done && (mc_rn == rx)) begin
                res.code = FWD_MC_C;
            end else begin
                res.code = FWD_RF_C;
            end
            for (int s = NFWD - 1; s >= 0; s--) begin
                if (s_wreg[s] && (s_rn[s*RW +: RW] == rx)) begin
                    res.code      = FW'(s + 1);
                    res.load_wait = ~s_ready[s];
                end
            end
        end else begin
            res.code = FWD_RF_C;
        end
        return res;
    endfunction

    assign fa_s = fwd_lookup(bus.d_ra, bus.d_need_ra, bus.s_wreg, bus.s_rn,
                             bus.s_ready, mc_done_s, mc_rn_s);
    assign fb_s = fwd_lookup(bus.d_rb, bus.d_need_rb, bus.s_wreg, bus.s_rn,
                             bus.s_ready, mc_done_s, mc_rn_s);

    // A pending operand is only usable in the cycle its result is on the mc bus.
    assign pend_a_s = bus.d_need_ra && (bus.d_ra != {RW{1'b0}}) &&
                      pending_r[bus.d_ra] && (fa_s.code != FWD_MC_C);
    assign pend_b_s = bus.d_need_rb && (bus.d_rb != {RW{1'b0}}) &&
                      pending_r[bus.d_rb] && (fb_s.code != FWD_MC_C);
    assign struct_s = bus.d_mc && mc_busy_s && !mc_done_s;
    assign waw_s    = bus.d_wreg && pending_r[bus.d_rn] &&
                      !(mc_done_s && (mc_rn_s == bus.d_rn));
    assign cond_s   = bus.d_cond_use && bus.e_setcond;

    // Stall reason, highest priority first; no reason means decode may advance.
    always_comb begin
        stall_reason_s = STALL_NONE;
        if (fa_s.load_wait || fb_s.load_wait) begin
            stall_reason_s = STALL_LOAD_USE;
        end else if (pend_a_s || pend_b_s) begin
            stall_reason_s = STALL_MC_PEND;
        end else if (struct_s) begin
            stall_reason_s = STALL_STRUCT;
        end else if (waw_s) begin
            stall_reason_s = STALL_WAW;
        end else if (cond_s) begin
            stall_reason_s = STALL_COND;
        end else begin
            stall_reason_s = STALL_NONE;
        end
    end

    assign d_available_s = (stall_reason_s == STALL_NONE);
    assign issue_s       = bus.d_valid && !bus.flush && d_available_s;

    // Set beats clear when the completing register is reissued the same cycle.
    assign set_mask_s = (issue_s && bus.d_mc && bus.d_wreg && (bus.d_rn != {RW{1'b0}}))
                        ? (NREG'(1) << bus.d_rn) : {NREG{1'b0}};
    assign clr_mask_s = (mc_done_s && mc_wreg_s)
                        ? (NREG'(1) << mc_rn_s) : {NREG{1'b0}};

    // Scoreboard of registers awaiting a multi-cycle result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= {NREG{1'b0}};
        end else begin
            pending_r <= (pending_r & ~clr_mask_s) | set_mask_s;
        end
    end

    mc_tracker #(
        .RW (RW),
        .LW (LW)
    ) u_mc_tracker (
        .clk     (clk),
        .rst     (rst),
        .issue   (issue_s && bus.d_mc),
        .lat     (bus.d_mc_lat),
        .rn      (bus.d_rn),
        .wreg    (bus.d_wreg),
        .mc_busy (mc_busy_s),
        .mc_done (mc_done_s),
        .mc_rn   (mc_rn_s),
        .mc_wreg (mc_wreg_s)
    );

    assign bus.d_available  = d_available_s;
    assign bus.forward_q1   = fa_s.code;
    assign bus.forward_q2   = fb_s.code;
    assign bus.mc_busy      = mc_busy_s;
    assign bus.mc_done      = mc_done_s;
    assign bus.mc_rn        = mc_rn_s;
    assign bus.stall_reason = stall_reason_s;

endmodule
